// File: rtl/cram_pkg.sv
// Shared constants for the CellularRAM/PSRAM device-side responder:
// FSM state encodings, configuration-register selectors and their reset values.
package cram_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_RWAIT = 3'd2;
    localparam logic [2:0] ST_DRIVE = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam logic [1:0] SEL_RCR  = 2'b00;
    localparam logic [1:0] SEL_DIDR = 2'b01;
    localparam logic [1:0] SEL_BCR  = 2'b10;

    localparam logic [15:0] BCR_DEFAULT  = 16'h9D1F;
    localparam logic [15:0] RCR_DEFAULT  = 16'h0010;
    localparam logic [15:0] DIDR_VALUE   = 16'h0000;

endpackage

// File: rtl/cram_responder_if.sv
// Address/data-multiplexed PSRAM pin bundle. The controller side is the master,
// the emulated memory chip is the slave.
interface cram_responder_if;

    logic [5:0]  a;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        adv_n;
    logic        cre;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;
    logic        wait_out;

    modport master (
        output a, dq_in, adv_n, cre, ce_n, oe_n, we_n, ub_n, lb_n,
        input  dq_out, dq_oe, wait_out
    );

    modport slave (
        input  a, dq_in, adv_n, cre, ce_n, oe_n, we_n, ub_n, lb_n,
        output dq_out, dq_oe, wait_out
    );

endinterface

// File: rtl/cram_responder_sync_2ff.sv
// Two-flop synchronizer for a vector of asynchronous control pins; each bit
// resets to its own inactive level.
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/cram_responder.sv
// Device-side CellularRAM/PSRAM model in muxed asynchronous mode: oversampled
// control pins, latency-timed reads, byte-masked writes and BCR/RCR registers.
module cram_responder
    import cram_pkg::*;
#(
    parameter int          ADDR_W       = 10,
    parameter int          READ_LATENCY = 4,
    parameter logic [15:0] BCR_RESET    = BCR_DEFAULT,
    parameter logic [15:0] RCR_RESET    = RCR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    cram_responder_if.slave    bus
);

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);

    logic [6:0]  ctrl_raw_s;
    logic [6:0]  ctrl_sync_s;
    logic        adv_n_s, cre_s, ce_n_s, oe_n_s, we_n_s, ub_n_s, lb_n_s;
    logic [21:0] bus_addr_s;

    logic [2:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [21:0]       areg_r;
    logic              reg_sel_r;
    logic [3:0]        cnt_r;
    logic [15:0]       wdata_r;
    logic [1:0]        be_r;
    logic [15:0]       bcr_r;
    logic [15:0]       rcr_r;
    logic [15:0]       dq_out_r;
    logic              dq_oe_r;
    logic              wait_r;
    logic [15:0]       mem_r [0:DEPTH-1];

    logic              commit_s;
    logic              array_wr_s;
    logic              reg_wr_s;
    logic [15:0]       rdata_s;

    // cre idles low; every other control is active-low and idles high.
    assign ctrl_raw_s = {bus.adv_n, bus.cre, bus.ce_n, bus.oe_n, bus.we_n, bus.ub_n, bus.lb_n};

    sync_2ff #(
        .WIDTH     (7),
        .RESET_VAL (7'b1011111)
    ) u_ctrl_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (ctrl_raw_s),
        .q     (ctrl_sync_s)
    );

    assign {adv_n_s, cre_s, ce_n_s, oe_n_s, we_n_s, ub_n_s, lb_n_s} = ctrl_sync_s;
    assign bus_addr_s = {bus.a, bus.dq_in};

    // The write is committed on the first cycle the synchronized we_n is seen high.
    assign commit_s   = (state_r == ST_WRITE) && !ce_n_s && we_n_s;
    assign array_wr_s = commit_s && !reg_sel_r;
    assign reg_wr_s   = commit_s && reg_sel_r;

    // Read data source: configuration registers when cre was latched, else the array.
    always_comb begin
        rdata_s = 16'h0000;
        if (reg_sel_r) begin
            case (areg_r[19:18])
                SEL_BCR:  rdata_s = bcr_r;
                SEL_RCR:  rdata_s = rcr_r;
                SEL_DIDR: rdata_s = DIDR_VALUE;
                default:  rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = mem_r[addr_r];
        end
    end

    // Bus protocol FSM; a deasserted chip enable overrides every other transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            areg_r    <= 22'h000000;
            reg_sel_r <= 1'b0;
            cnt_r     <= 4'd0;
            wdata_r   <= 16'h0000;
            be_r      <= 2'b00;
            dq_out_r  <= 16'h0000;
            dq_oe_r   <= 1'b0;
            wait_r    <= 1'b0;
        end else if (ce_n_s) begin
            state_r <= ST_IDLE;
            dq_oe_r <= 1'b0;
            wait_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!adv_n_s) begin
                        addr_r    <= bus_addr_s[ADDR_W-1:0];
                        areg_r    <= bus_addr_s;
                        reg_sel_r <= cre_s;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!adv_n_s) begin
                        addr_r    <= bus_addr_s[ADDR_W-1:0];
                        areg_r    <= bus_addr_s;
                        reg_sel_r <= cre_s;
                    end else if (!we_n_s) begin
                        wdata_r <= bus.dq_in;
                        be_r    <= {~ub_n_s, ~lb_n_s};
                        state_r <= ST_WRITE;
                    end else if (!oe_n_s) begin
                        cnt_r   <= LAT_LOAD;
                        wait_r  <= 1'b1;
                        state_r <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (oe_n_s || !we_n_s) begin
                        wait_r  <= 1'b0;
                        state_r <= ST_ADDR;
                    end else if (cnt_r == 4'd0) begin
                        dq_out_r <= rdata_s;
                        dq_oe_r  <= 1'b1;
                        wait_r   <= 1'b0;
                        state_r  <= ST_DRIVE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DRIVE: begin
                    if (oe_n_s) begin
                        dq_oe_r <= 1'b0;
                        state_r <= ST_ADDR;
                    end
                end
                ST_WRITE: begin
                    if (we_n_s) begin
                        state_r <= ST_ADDR;
                    end else begin
                        wdata_r <= bus.dq_in;
                        be_r    <= {~ub_n_s, ~lb_n_s};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    dq_oe_r <= 1'b0;
                    wait_r  <= 1'b0;
                end
            endcase
        end
    end

    // Configuration registers take their value from the latched address, not dq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcr_r <= BCR_RESET;
            rcr_r <= RCR_RESET;
        end else if (reg_wr_s) begin
            case (areg_r[19:18])
                SEL_BCR: bcr_r <= areg_r[15:0];
                SEL_RCR: rcr_r <= areg_r[15:0];
                default: ;
            endcase
        end
    end

    // Storage array survives reset, like the real part.
    always_ff @(posedge clk) begin
        if (array_wr_s) begin
            if (be_r[1]) mem_r[addr_r][15:8] <= wdata_r[15:8];
            if (be_r[0]) mem_r[addr_r][7:0]  <= wdata_r[7:0];
        end
    end

    // Drive only while the controller still asserts oe_n, so the bus never fights.
    assign bus.dq_oe    = dq_oe_r && !oe_n_s;
    assign bus.dq_out   = dq_out_r;
    assign bus.wait_out = wait_r;

endmodule

// File: tb/tb_cram_responder.sv
// Randomized self-checking bench for cram_responder against a word-array and
// register model of the PSRAM device.
module tb_cram_responder;

    localparam int ADDR_W       = 10;
    localparam int READ_LATENCY = 4;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    logic [15:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [15:0] ref_bcr;
    logic [15:0] ref_rcr;
    logic [21:0] pool [0:7];

    cram_responder_if bus();

    cram_responder #(
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (READ_LATENCY),
        .BCR_RESET    (16'h9D1F),
        .RCR_RESET    (16'h0010)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] ref_read(input logic [21:0] ad, input logic c);
        if (c) begin
            if (ad[19:18] == 2'b10)      return ref_bcr;
            else if (ad[19:18] == 2'b00) return ref_rcr;
            else                         return 16'h0000;
        end
        return ref_mem[ad[ADDR_W-1:0]];
    endfunction

    task automatic bus_idle();
        bus.ce_n  = 1'b1;
        bus.adv_n = 1'b1;
        bus.oe_n  = 1'b1;
        bus.we_n  = 1'b1;
        bus.ub_n  = 1'b1;
        bus.lb_n  = 1'b1;
        bus.cre   = 1'b0;
        tick(4);
    endtask

    task automatic addr_phase(input logic [21:0] ad, input logic c);
        bus.cre   = c;
        bus.a     = ad[21:16];
        bus.dq_in = ad[15:0];
        bus.ce_n  = 1'b0;
        bus.adv_n = 1'b0;
        tick(4);
        bus.adv_n = 1'b1;
        tick(4);
    endtask

    task automatic do_write(input logic [21:0] ad, input logic [15:0] data,
                            input logic ub, input logic lb, input logic c);
        addr_phase(ad, c);
        bus.dq_in = data;
        bus.ub_n  = ub;
        bus.lb_n  = lb;
        bus.we_n  = 1'b0;
        tick(5);
        bus.we_n  = 1'b1;
        tick(5);
        bus_idle();
        if (c) begin
            if (ad[19:18] == 2'b10)      ref_bcr = ad[15:0];
            else if (ad[19:18] == 2'b00) ref_rcr = ad[15:0];
        end else begin
            if (!ub) ref_mem[ad[ADDR_W-1:0]][15:8] = data[15:8];
            if (!lb) ref_mem[ad[ADDR_W-1:0]][7:0]  = data[7:0];
        end
    endtask

    task automatic do_read(input logic [21:0] ad, input logic c, input string tag);
        int wcnt;
        int cyc;
        wcnt = 0;
        cyc  = 0;
        addr_phase(ad, c);
        bus.dq_in = 16'h0000;
        bus.oe_n  = 1'b0;
        while (!bus.dq_oe && cyc < 40) begin
            tick(1);
            cyc++;
            if (bus.wait_out) wcnt++;
        end
        check({tag, "_oe"}, 32'(bus.dq_oe), 32'd1);
        check({tag, "_wait_cycles"}, 32'(wcnt), 32'(READ_LATENCY));
        check({tag, "_data"}, 32'(bus.dq_out), 32'(ref_read(ad, c)));
        check({tag, "_wait_low"}, 32'(bus.wait_out), 32'd0);
        bus.oe_n = 1'b1;
        tick(3);
        check({tag, "_release"}, 32'(bus.dq_oe), 32'd0);
        bus_idle();
    endtask

    initial begin
        int cyc;
        logic [21:0] ad;
        n_checks = 0;
        n_fail   = 0;
        ref_bcr  = 16'h9D1F;
        ref_rcr  = 16'h0010;
        bus.a     = 6'h00;
        bus.dq_in = 16'h0000;
        reset_n   = 1'b0;
        bus_idle();
        check("reset_dq_out", 32'(bus.dq_out), 32'd0);
        check("reset_dq_oe", 32'(bus.dq_oe), 32'd0);
        check("reset_wait", 32'(bus.wait_out), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Directed: write/read, byte mask, wrap, configuration registers.
        do_write(22'h000005, 16'hA5C3, 1'b0, 1'b0, 1'b0);
        do_read(22'h000005, 1'b0, "wr_rd");
        do_write(22'h000005, 16'h1234, 1'b1, 1'b0, 1'b0);
        do_read(22'h000005, 1'b0, "byte_mask");
        do_write(22'h000407, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        do_read(22'h000007, 1'b0, "wrap");
        do_read(22'h080000, 1'b1, "bcr_reset");
        do_write(22'h088010, 16'h5A5A, 1'b0, 1'b0, 1'b1);
        do_read(22'h080000, 1'b1, "bcr_write");
        do_read(22'h040000, 1'b1, "didr");
        do_read(22'h0C0000, 1'b1, "sel_11");
        do_read(22'h000000, 1'b1, "rcr_reset");

        // Chip enable dropped mid-write: the word must be unchanged.
        addr_phase(22'h000005, 1'b0);
        bus.dq_in = 16'hFFFF;
        bus.ub_n  = 1'b0;
        bus.lb_n  = 1'b0;
        bus.we_n  = 1'b0;
        tick(5);
        bus.ce_n  = 1'b1;
        tick(5);
        bus.we_n  = 1'b1;
        tick(3);
        bus_idle();
        do_read(22'h000005, 1'b0, "abort_write");

        // Chip enable dropped during the latency wait.
        addr_phase(22'h000007, 1'b0);
        bus.oe_n = 1'b0;
        cyc = 0;
        while (!bus.wait_out && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check("abort_rwait_seen", 32'(bus.wait_out), 32'd1);
        bus.ce_n = 1'b1;
        tick(3);
        check("abort_rwait_wait", 32'(bus.wait_out), 32'd0);
        check("abort_rwait_oe", 32'(bus.dq_oe), 32'd0);
        bus_idle();

        // Random traffic over a small address pool, each word fully written first.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 22'($urandom());
            do_write(pool[i], 16'($urandom()), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ad = 22'($urandom());
                if ($urandom_range(0, 1) == 1)
                    do_write(ad, 16'($urandom()), 1'b0, 1'b0, 1'b1);
                else
                    do_read(ad, 1'b1, "rand_reg");
            end else begin
                ad = pool[$urandom_range(0, 7)];
                if ($urandom_range(0, 1) == 1)
                    do_write(ad, 16'($urandom()), 1'($urandom()), 1'($urandom()), 1'b0);
                else
                    do_read(ad, 1'b0, "rand_mem");
            end
        end

        // Reset while driving: outputs clear at once, array survives, registers reload.
        addr_phase(pool[0], 1'b0);
        bus.oe_n = 1'b0;
        cyc = 0;
        while (!bus.dq_oe && cyc < 40) begin
            tick(1);
            cyc++;
        end
        check("rst_drive_reached", 32'(bus.dq_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_dq_oe", 32'(bus.dq_oe), 32'd0);
        check("rst_wait", 32'(bus.wait_out), 32'd0);
        check("rst_dq_out", 32'(bus.dq_out), 32'd0);
        ref_bcr = 16'h9D1F;
        ref_rcr = 16'h0010;
        tick(2);
        bus_idle();
        reset_n = 1'b1;
        tick(2);
        do_read(22'h080000, 1'b1, "rst_bcr");
        do_read(22'h000000, 1'b1, "rst_rcr");
        do_read(pool[0], 1'b0, "rst_mem_pool");
        do_read(22'h000007, 1'b0, "rst_mem_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
